systolic_mm_feeder: RTL and testbench
=====================================

Name: systolic_mm_feeder

Overview:
- Upstream feeder stage for the 2x2 SYSTOLIC array.
- Receives two 2x2 operand matrices as a 32-bit word stream and buffers them.
- Drives the array's row and column inputs with the diagonal wavefront skew it requires: row 2 and column 2 lag row 1 and column 1 by one cycle.
- Then holds zeros for a drain window and pulses done so the downstream reader can sample o_data_11..o_data_22.
- Matrix-multiply mode only; func_sel is driven to 0.

Parameters:
- DATA_WIDTH, 32, width of stream words and array operands.
- DRAIN_CYCLES, 4, zero-input cycles after the last operand before done is raised. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- s_tvalid  input  1  operand word valid
- s_tready  output  1  feeder can accept a word
- s_tdata  input  DATA_WIDTH  operand word
- s_tlast  input  1  marks the 8th word of a job
- sa_rst  output  1  active-high clear to the array, one cycle before feeding
- func_sel  output  1  constant 0 (matrix multiplication)
- i_data_11  output  DATA_WIDTH  row-1 A operand
- i_data_21  output  DATA_WIDTH  row-2 A operand
- i_tap_11  output  DATA_WIDTH  column-1 B operand
- i_tap_12  output  DATA_WIDTH  column-2 B operand
- busy  output  1  job in progress (any state except IDLE)
- done  output  1  one-cycle pulse; array results are valid this cycle
- err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, word count=0, buffer cleared.
  - All data outputs 0; sa_rst, done, err, busy all 0; s_tready=0.
- Word order, accepted on s_tvalid&&s_tready: a11, a12, a21, a22, b11, b12, b21, b22.
- IDLE:
  - s_tready=1.
  - First accepted word is stored and moves the FSM to LOAD with count=1.
- LOAD:
  - s_tready=1.
  - Each accepted word is stored at index count, then count increments.
  - Accepted word with s_tlast=1 and count<7: err pulse, return to IDLE; the partial buffer is discarded.
  - 8th word (count=7) with s_tlast=0: err pulse, return to IDLE.
  - 8th word with s_tlast=1: go to CLR.
  - A word with s_tlast=1 accepted in IDLE is also an error; stay in IDLE.
- CLR: one cycle, s_tready=0, sa_rst=1, then go to FEED.
- FEED: 3 cycles, t=0,1,2, s_tready=0. All outputs are registered.
  - t=0: i_data_11=a11, i_tap_11=b11, i_data_21=0, i_tap_12=0.
  - t=1: i_data_11=a12, i_tap_11=b21, i_data_21=a21, i_tap_12=b12.
  - t=2: i_data_11=0, i_tap_11=0, i_data_21=a22, i_tap_12=b22.
- DRAIN:
  - All four operand outputs are 0 for DRAIN_CYCLES cycles.
  - On the final drain cycle, done=1 for that cycle, then return to IDLE.
- done pulse timing: exactly 1 (CLR) + 3 (FEED) + DRAIN_CYCLES cycles after the accepting edge of word 8.
- Back-to-back jobs: s_tready re-asserts in the cycle after done. The next job may start immediately, with no bubble required.
- Stream stalls in LOAD (s_tvalid=0) hold count; there is no timeout.
- Values are passed through unmodified; there is no arithmetic in the feeder.
- Reset mid-job aborts immediately:
  - Outputs go to 0 asynchronously.
  - No done or err is produced.

Optional Feature:
- Macro SYSTOLIC_FEEDER_PERF_EN.
- When defined, the block adds:
  - Output port job_cnt[15:0]: counts completed jobs (done pulses), wraps 0xFFFF->0.
  - Output port err_cnt[7:0]: counts err pulses, saturates at 0xFF.
  - Both counters are reset by rst_n only.
- When undefined, neither port nor any counter logic exists, and the interface is exactly as listed above.

Decomposition:
- Shared package systolic_pkg holds:
  - FSM state enum: IDLE, LOAD, CLR, FEED, DRAIN.
  - Constants MAT_DIM=2 and JOB_WORDS=8.
  - Default DATA_WIDTH.
- One sub-module, systolic_operand_buf: 8-entry DATA_WIDTH register file.
  - Write port: index + enable.
  - Read: fully combinational, 8 parallel outputs.
  - Has its own async active-low reset.
- Skew muxing and the FSM stay in the top module.

Test Plan:
- Nominal job: A=[[1,2],[3,4]], B=[[5,6],[7,8]], streamed with no gaps.
  - Required operand sequence on i_data_11: 1,2,0. On i_data_21: 0,3,4.
  - Required sequence on i_tap_11: 5,7,0. On i_tap_12: 0,6,8.
  - done fires 8 cycles after word 8 (DRAIN_CYCLES=4).
  - Array model outputs C=[[19,22],[43,50]].
- Stalled stream: s_tvalid toggles 1,0,0,1 between words.
  - Same outputs as the nominal job; done latency is still counted from word 8.
- Early tlast on word 3: err pulses once, s_tready stays high, busy drops, and no FEED occurs.
  - The following clean job completes normally.
- Missing tlast on word 8: err pulses once and the FSM returns to IDLE.
- Back-to-back jobs with A=I and B=[[9,9],[9,9]] twice:
  - Two done pulses, 8 words + 8 cycles apart.
  - sa_rst pulses once per job.
- rst_n asserted during FEED at t=1:
  - Outputs go to 0 immediately; no done is produced.
  - After release, a fresh job completes.
  - With SYSTOLIC_FEEDER_PERF_EN defined, job_cnt reads 1 after that job completes.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic feeder.
package systolic_pkg;
  localparam int MAT_DIM        = 2;
  localparam int JOB_WORDS      = 8;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    FEED,
    DRAIN
  } state_t;
endpackage

// File: rtl/systolic_operand_buf.sv
// Eight-entry operand register file: one indexed write port, all entries readable in parallel.
module systolic_operand_buf
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [$clog2(JOB_WORDS)-1:0]           wr_idx,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [JOB_WORDS-1:0][DATA_WIDTH-1:0]   rd_data
);

  logic [JOB_WORDS-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/systolic_mm_feeder.sv
// Operand feeder for the 2x2 systolic array: buffers a,b words and drives them with diagonal skew.
// Optional SYSTOLIC_FEEDER_PERF_EN adds job_cnt / err_cnt counters.
//
// state | meaning
// IDLE  | waiting for first word of a job
// LOAD  | collecting words 2..8
// CLR   | clearing the array (sa_rst)
// FEED  | three skewed operand cycles
// DRAIN | zero operands while the array settles; done on last cycle
module systolic_mm_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic                  sa_rst,
  output logic                  func_sel,
  output logic [DATA_WIDTH-1:0] i_data_11,
  output logic [DATA_WIDTH-1:0] i_data_21,
  output logic [DATA_WIDTH-1:0] i_tap_11,
  output logic [DATA_WIDTH-1:0] i_tap_12,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]           job_cnt,
  output logic [7:0]            err_cnt
`endif
);

  localparam int               IDX_W    = $clog2(JOB_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(JOB_WORDS - 1);
  localparam logic [3:0]       FEED_LD  = 4'(2 * MAT_DIM - 2);
  localparam logic [3:0]       DRAIN_LD = 4'(DRAIN_CYCLES - 1);

  state_t                               state, state_nxt;
  logic [IDX_W-1:0]                     cnt, cnt_nxt;
  logic [3:0]                           tmr, tmr_nxt;
  logic                                 err_nxt;
  logic                                 accept;
  logic                                 wr_en;
  logic [IDX_W-1:0]                     wr_idx;
  logic [JOB_WORDS-1:0][DATA_WIDTH-1:0] opnd;
  logic [DATA_WIDTH-1:0]                d11_nxt, d21_nxt, t11_nxt, t12_nxt;

  assign accept = s_tvalid && s_tready;

  systolic_operand_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (s_tdata),
    .rd_data (opnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tmr      <= '0;
      err      <= 1'b0;
      s_tready <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tmr      <= tmr_nxt;
      err      <= err_nxt;
      s_tready <= (state_nxt == IDLE) || (state_nxt == LOAD);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmr_nxt   = tmr;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_tlast) begin
            err_nxt = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            cnt_nxt   = IDX_W'(1);
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if (s_tlast) begin
              state_nxt = CLR;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end else if (s_tlast) begin
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + IDX_W'(1);
          end
        end
      end
      CLR: begin
        state_nxt = FEED;
        tmr_nxt   = FEED_LD;
      end
      FEED: begin
        if (tmr == 4'd0) begin
          state_nxt = DRAIN;
          tmr_nxt   = DRAIN_LD;
        end else begin
          tmr_nxt = tmr - 4'd1;
        end
      end
      DRAIN: begin
        if (tmr == 4'd0) state_nxt = IDLE;
        else             tmr_nxt   = tmr - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are registered: values for the next FEED step are chosen one cycle ahead.
  // Buffer layout: a11 a12 a21 a22 b11 b12 b21 b22 at indices 0..7.
  always_comb begin
    d11_nxt = '0;
    d21_nxt = '0;
    t11_nxt = '0;
    t12_nxt = '0;
    if (state == CLR) begin
      d11_nxt = opnd[0];
      t11_nxt = opnd[4];
    end else if (state == FEED && tmr == FEED_LD) begin
      d11_nxt = opnd[1];
      t11_nxt = opnd[6];
      d21_nxt = opnd[2];
      t12_nxt = opnd[5];
    end else if (state == FEED && tmr == FEED_LD - 4'd1) begin
      d21_nxt = opnd[3];
      t12_nxt = opnd[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data_11 <= '0;
      i_data_21 <= '0;
      i_tap_11  <= '0;
      i_tap_12  <= '0;
    end else begin
      i_data_11 <= d11_nxt;
      i_data_21 <= d21_nxt;
      i_tap_11  <= t11_nxt;
      i_tap_12  <= t12_nxt;
    end
  end

  assign sa_rst   = (state == CLR);
  assign busy     = (state != IDLE);
  assign done     = (state == DRAIN) && (tmr == 4'd0);
  assign func_sel = 1'b0;

`ifdef SYSTOLIC_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (done) job_cnt <= job_cnt + 16'd1;
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_mm_feeder.sv
// Self-checking bench for systolic_mm_feeder: vector table of jobs, operand/result scoreboard, corner sequences.
module tb_systolic_mm_feeder;
  localparam int DW    = 32;
  localparam int DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          sa_rst, func_sel, busy, done, err;
  logic [DW-1:0] i_data_11, i_data_21, i_tap_11, i_tap_12;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]   job_cnt;
  logic [7:0]    err_cnt;
`endif

  systolic_mm_feeder #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .sa_rst    (sa_rst),
    .func_sel  (func_sel),
    .i_data_11 (i_data_11),
    .i_data_21 (i_data_21),
    .i_tap_11  (i_tap_11),
    .i_tap_12  (i_tap_12),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .job_cnt   (job_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d11, t11, d21, t12;
  } op_t;
  typedef struct packed {
    logic [31:0] c11, c12, c21, c22;
  } c_t;
  typedef struct {
    logic [7:0][31:0] w;
    int               tlast_at;
    bit               stall;
    bit               exp_err;
  } vec_t;

  op_t  op_q[$];
  c_t   c_q[$];
  vec_t vecs[7];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  int err_seen = 0, done_seen = 0, sarst_seen = 0;
  int last_done = 0, prev_done = 0;
  int phase = 0;
  logic [31:0] acc11, acc12, acc21, acc22, a_r11, b_r11, b_r12, a_r21;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][31:0] mkw(input int a11, a12, a21, a22, b11, b12, b21, b22);
    logic [7:0][31:0] w;
    w[0] = 32'(a11); w[1] = 32'(a12); w[2] = 32'(a21); w[3] = 32'(a22);
    w[4] = 32'(b11); w[5] = 32'(b12); w[6] = 32'(b21); w[7] = 32'(b22);
    return w;
  endfunction

  // Reference: skewed operand schedule and plain 2x2 matrix product.
  task automatic push_exp(input logic [7:0][31:0] w);
    op_q.push_back(op_t'{w[0], w[4], 32'd0, 32'd0});
    op_q.push_back(op_t'{w[1], w[6], w[2], w[5]});
    op_q.push_back(op_t'{32'd0, 32'd0, w[3], w[7]});
    c_q.push_back(c_t'{w[0]*w[4] + w[1]*w[6], w[0]*w[5] + w[1]*w[7],
                       w[2]*w[4] + w[3]*w[6], w[2]*w[5] + w[3]*w[7]});
  endtask

  // Output-stationary 2x2 array model fed from the DUT's operand outputs.
  task automatic model_step();
    acc11 += i_data_11 * i_tap_11;
    acc12 += a_r11 * i_tap_12;
    acc21 += i_data_21 * b_r11;
    acc22 += a_r21 * b_r12;
    a_r11 = i_data_11;
    b_r11 = i_tap_11;
    b_r12 = i_tap_12;
    a_r21 = i_data_21;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
    end else begin
      if (err) begin
        err_seen++;
        chk("err_tready_high", 32'(s_tready), 32'd1);
        chk("err_busy_low", 32'(busy), 32'd0);
      end
      if (sa_rst) begin
        sarst_seen++;
        {acc11, acc12, acc21, acc22, a_r11, b_r11, b_r12, a_r21} = '0;
        phase = 1;
      end else if (phase >= 1 && phase <= 3) begin
        if (op_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL feed_unexpected: operands driven with no job expected (t=%0t)", $time);
        end else begin
          op_t e;
          e = op_q.pop_front();
          chk("i_data_11", i_data_11, e.d11);
          chk("i_tap_11", i_tap_11, e.t11);
          chk("i_data_21", i_data_21, e.d21);
          chk("i_tap_12", i_tap_12, e.t12);
        end
        chk("done_in_feed", 32'(done), 32'd0);
        model_step();
        phase++;
      end else if (phase >= 4) begin
        chk("drain_zero", i_data_11 | i_tap_11 | i_data_21 | i_tap_12, 32'd0);
        model_step();
        if (done) begin
          chk("done_latency", 32'(cyc - acc_cyc), 32'(4 + DRAIN));
          if (c_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result_unexpected: done with no job expected (t=%0t)", $time);
          end else begin
            c_t c;
            c = c_q.pop_front();
            chk("c11", acc11, c.c11);
            chk("c12", acc12, c.c12);
            chk("c21", acc21, c.c21);
            chk("c22", acc22, c.c22);
          end
          done_seen++;
          prev_done = last_done;
          last_done = cyc;
          phase = 0;
        end else if (phase == 3 + DRAIN) begin
          checks++;
          errors++;
          $display("FAIL done_missing: no done after %0d drain cycles (t=%0t)", DRAIN, $time);
          phase = 0;
        end else begin
          phase++;
        end
      end else begin
        chk("done_idle", 32'(done), 32'd0);
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    bit acc = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (s_tready) begin
        acc = 1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 50 cycles", d);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int e0 = err_seen, d0 = done_seen, n = 0;
    if (!v.exp_err) push_exp(v.w);
    for (int i = 0; i < 8; i++) begin
      send_word(v.w[i], i == v.tlast_at);
      if (i == v.tlast_at) break;
      if (v.stall) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    if (v.exp_err) begin
      repeat (3) @(posedge clk);
      #1;
    end else begin
      while (done_seen == d0 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("err_pulses", 32'(err_seen - e0), 32'(v.exp_err));
    chk("done_pulses", 32'(done_seen - d0), 32'(!v.exp_err));
    chk("busy_after_job", 32'(busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {31'd0, s_tready} | {31'd0, busy} | {31'd0, done} | {31'd0, err} |
            {31'd0, sa_rst} | {31'd0, func_sel} | i_data_11 | i_data_21 | i_tap_11 | i_tap_12,
        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] ident9;
    int d0, s0, n;

    vecs[0] = '{w: mkw(1, 2, 3, 4, 5, 6, 7, 8), tlast_at: 7, stall: 0, exp_err: 0};
    vecs[1] = '{w: mkw(1, 2, 3, 4, 5, 6, 7, 8), tlast_at: 7, stall: 1, exp_err: 0};
    vecs[2] = '{w: mkw(11, 12, 13, 14, 15, 16, 17, 18), tlast_at: 2, stall: 0, exp_err: 1};
    vecs[3] = '{w: mkw(2, 0, 1, 3, 4, 5, 6, 7), tlast_at: 7, stall: 0, exp_err: 0};
    vecs[4] = '{w: mkw(1, 1, 1, 1, 2, 2, 2, 2), tlast_at: 8, stall: 0, exp_err: 1};
    vecs[5] = '{w: mkw(5, 5, 5, 5, 5, 5, 5, 5), tlast_at: 0, stall: 0, exp_err: 1};
    vecs[6] = '{w: mkw(-1, 32'h1234_5678, 32'h8000_0000, 7, 3, -2, 32'h0F0F_0F0F, 1),
                tlast_at: 7, stall: 1, exp_err: 0};

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 32'(s_tready), 32'd1);
    chk("busy_after_reset", 32'(busy), 32'd0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Back-to-back: A = I, B = all nines, twice with no gap.
    ident9 = mkw(1, 0, 0, 1, 9, 9, 9, 9);
    d0 = done_seen;
    s0 = sarst_seen;
    push_exp(ident9);
    push_exp(ident9);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 8; i++) send_word(ident9[i], i == 7);
    n = 0;
    while (done_seen < d0 + 2 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_done_pulses", 32'(done_seen - d0), 32'd2);
    chk("b2b_sarst_pulses", 32'(sarst_seen - s0), 32'd2);
    chk("b2b_done_spacing", 32'(last_done - prev_done), 32'd16);

    // Reset in the middle of FEED (t=1).
    push_exp(vecs[0].w);
    for (int i = 0; i < 8; i++) send_word(vecs[0].w[i], i == 7);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("feed_t1_data_21", i_data_21, 32'd3);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset_outputs");
    op_q.delete();
    c_q.delete();
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done_seen - d0), 32'd0);
    run_vec(vecs[0]);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    chk("job_cnt", 32'(job_cnt), 32'd1);
    chk("err_cnt", 32'(err_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
